// File: rtl/uart_rx_frontend_pkg.sv
// uart_rx_frontend_pkg
// Shared constants and helpers for the UART receive front end.
// Contents:
//   UART_DL_W        - default divisor latch width
//   UART_LINE_IDLE   - level of an idle serial line
//   UART_SYNC_STAGES - default synchroniser depth (2 or 3)
//   maj3()           - 2-of-3 majority vote used by the optional glitch filter
// Optional feature: UART_RX_GLITCH_FILTER_EN (majority filter, used in uart_sync_filter).
package uart_rx_frontend_pkg;

  localparam int   UART_DL_W        = 16;
  localparam logic UART_LINE_IDLE   = 1'b1;
  localparam int   UART_SYNC_STAGES = 2;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_frontend_if.sv
// uart_rx_frontend_if
// Groups the front end's line, divisor and output signals.
// Signals:
//   srx_pad_i, stx_pad_i, loopback - serial sources and source select
//   dl, dl_we                      - divisor latch value and reload strobe
//   srx_o, enable, rx_fall         - conditioned line, 16x tick, falling-edge pulse
// Modports: master drives the inputs and observes the outputs; slave is the front end.
interface uart_rx_frontend_if
  import uart_rx_frontend_pkg::*;
#(
  parameter int DL_W = UART_DL_W
);

  logic            srx_pad_i;
  logic            stx_pad_i;
  logic            loopback;
  logic [DL_W-1:0] dl;
  logic            dl_we;
  logic            srx_o;
  logic            enable;
  logic            rx_fall;

  modport master (
    output srx_pad_i, stx_pad_i, loopback, dl, dl_we,
    input  srx_o, enable, rx_fall
  );

  modport slave (
    input  srx_pad_i, stx_pad_i, loopback, dl, dl_we,
    output srx_o, enable, rx_fall
  );

endinterface

// File: rtl/uart_sync_filter.sv
// uart_sync_filter
// Synchronises the selected serial source into clk, optionally majority-filters
// single-cycle glitches, and flags 1->0 transitions of the conditioned line.
// Ports:
//   clk        - system clock
//   wb_rst_ni  - asynchronous active-low reset (line flops reset to idle)
//   src_i      - selected serial source, asynchronous to clk
//   srx_o      - conditioned serial line (registered)
//   rx_fall_o  - one-cycle pulse in the first cycle srx_o reads 0 (registered)
// Optional feature: UART_RX_GLITCH_FILTER_EN adds two history flops and a 2-of-3
// vote, adding two cycles of latency and suppressing 1-clk pulses.
module uart_sync_filter
  import uart_rx_frontend_pkg::*;
#(
  parameter int SYNC_STAGES = UART_SYNC_STAGES
) (
  input  logic clk,
  input  logic wb_rst_ni,
  input  logic src_i,
  output logic srx_o,
  output logic rx_fall_o
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   s_q;
  logic                   srx_cur;
  logic                   srx_next;
  logic                   rx_fall_q, rx_fall_d;

  assign sync_d = {sync_q[SYNC_STAGES-2:0], src_i};
  assign s_q    = sync_q[SYNC_STAGES-1];

  // Synchroniser chain; the last stage is the synchronised line.
  always_ff @(posedge clk or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      sync_q <= {SYNC_STAGES{UART_LINE_IDLE}};
    end else begin
      sync_q <= sync_d;
    end
  end

`ifdef UART_RX_GLITCH_FILTER_EN
  logic h1_q, h2_q, srx_q;

  // History of the synchronised line plus the registered vote; a level must
  // persist for two samples before it wins the 2-of-3 majority.
  always_ff @(posedge clk or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      h1_q  <= UART_LINE_IDLE;
      h2_q  <= UART_LINE_IDLE;
      srx_q <= UART_LINE_IDLE;
    end else begin
      h1_q  <= s_q;
      h2_q  <= h1_q;
      srx_q <= srx_next;
    end
  end

  assign srx_next = maj3(s_q, h1_q, h2_q);
  assign srx_cur  = srx_q;
`else
  // Without the filter the last synchroniser stage is the output register, so
  // the value it will take next is the stage feeding it.
  assign srx_next = sync_q[SYNC_STAGES-2];
  assign srx_cur  = s_q;
`endif

  // The edge flag is computed from the line's next value so that it rises in
  // the same cycle srx_o first reads 0.
  assign rx_fall_d = srx_cur & ~srx_next;

  always_ff @(posedge clk or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      rx_fall_q <= 1'b0;
    end else begin
      rx_fall_q <= rx_fall_d;
    end
  end

  assign srx_o     = srx_cur;
  assign rx_fall_o = rx_fall_q;

endmodule

// File: rtl/uart_rx_frontend.sv
// uart_rx_frontend
// Receive-side front end feeding the UART receiver: selects pad or loopback
// source, conditions it (uart_sync_filter) and generates the 16x baud enable
// from the divisor latch.
// Ports:
//   clk        - system clock (single domain)
//   wb_rst_ni  - asynchronous active-low reset
//   bus        - uart_rx_frontend_if.slave: srx_pad_i, stx_pad_i, loopback,
//                dl, dl_we in; srx_o, enable, rx_fall out (all registered)
// Optional feature: UART_RX_GLITCH_FILTER_EN (majority glitch filter in uart_sync_filter).
module uart_rx_frontend
  import uart_rx_frontend_pkg::*;
#(
  parameter int DL_W        = UART_DL_W,
  parameter int SYNC_STAGES = UART_SYNC_STAGES
) (
  input  logic                     clk,
  input  logic                     wb_rst_ni,
  uart_rx_frontend_if.slave        bus
);

  logic            src;
  logic [DL_W-1:0] dlc_q, dlc_d;
  logic            enable_q, enable_d;

  // Loopback is muxed ahead of the synchroniser, so switching source looks
  // like an ordinary line edge downstream.
  assign src = bus.loopback ? bus.stx_pad_i : bus.srx_pad_i;

  uart_sync_filter #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync_filter (
    .clk       (clk),
    .wb_rst_ni (wb_rst_ni),
    .src_i     (src),
    .srx_o     (bus.srx_o),
    .rx_fall_o (bus.rx_fall)
  );

  // Divisor down-counter. A zero divisor parks the counter at 0 so that the
  // first tick appears one cycle after dl becomes non-zero; a dl_we strobe
  // reloads dl-1 so the first tick lands exactly dl cycles later.
  always_comb begin
    dlc_d    = dlc_q;
    enable_d = 1'b0;
    if (bus.dl == '0) begin
      dlc_d = '0;
    end else if (bus.dl_we) begin
      dlc_d = bus.dl - DL_W'(1);
    end else if (dlc_q == '0) begin
      enable_d = 1'b1;
      dlc_d    = bus.dl - DL_W'(1);
    end else begin
      dlc_d = dlc_q - DL_W'(1);
    end
  end

  always_ff @(posedge clk or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      dlc_q    <= '0;
      enable_q <= 1'b0;
    end else begin
      dlc_q    <= dlc_d;
      enable_q <= enable_d;
    end
  end

  assign bus.enable = enable_q;

endmodule

// File: tb/tb_uart_rx_frontend.sv
// tb_uart_rx_frontend
// Directed self-checking bench for uart_rx_frontend. Inputs are driven and
// outputs sampled on the falling clock edge; "edge k" means the k-th rising
// edge after the stimulus change.
// Optional feature: UART_RX_GLITCH_FILTER_EN changes the expected line latency
// and the minimum pulse width that passes.
module tb_uart_rx_frontend;
  import uart_rx_frontend_pkg::*;

  localparam int SYNC = UART_SYNC_STAGES;
`ifdef UART_RX_GLITCH_FILTER_EN
  localparam int LAT  = SYNC + 2;
  localparam int MINW = 2;
`else
  localparam int LAT  = SYNC;
  localparam int MINW = 1;
`endif

  logic clk = 1'b0;
  logic wb_rst_ni;
  int   checks = 0;
  int   errors = 0;

  uart_rx_frontend_if #(.DL_W(UART_DL_W)) bus ();

  uart_rx_frontend #(
    .DL_W        (UART_DL_W),
    .SYNC_STAGES (SYNC)
  ) dut (
    .clk       (clk),
    .wb_rst_ni (wb_rst_ni),
    .bus       (bus.slave)
  );

  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Drives the serial line inputs.
  task automatic applyStimulus(input logic srx, input logic stx, input logic lb);
    bus.srx_pad_i = srx;
    bus.stx_pad_i = stx;
    bus.loopback  = lb;
  endtask

  // Presents a new divisor with a one-cycle dl_we; returns just after the
  // strobe's rising edge (edge t), so the next sampled edge is t+1.
  task automatic loadDivisor(input int value);
    bus.dl    = UART_DL_W'(value);
    bus.dl_we = 1'b1;
    @(negedge clk);
    bus.dl_we = 1'b0;
  endtask

  // Expects enable high at edges firstK, firstK+period, ... within 1..n.
  task automatic watchEnable(input string tag, input int n, input int period,
                             input int firstK);
    logic expEn;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      expEn = (k >= firstK) && (((k - firstK) % period) == 0);
      checkOutput($sformatf("%s k=%0d", tag, k), 32'(bus.enable), 32'(expEn));
    end
  endtask

  // which: 0 = srx_pad_i, 1 = stx_pad_i, 2 = loopback (0 selects a low srx_pad_i).
  task automatic driveLine(input int which, input logic v);
    case (which)
      0:       bus.srx_pad_i = v;
      1:       bus.stx_pad_i = v;
      default: bus.loopback  = v;
    endcase
  endtask

  // Drives a low pulse of w clocks (w=0: permanent step) on the chosen source
  // and checks srx_o and rx_fall at every following edge.
  task automatic watchPulse(input string tag, input int w, input int which);
    bit   passes;
    int   span;
    logic expLow;
    logic expFall;
    passes = (w == 0) || (w >= MINW);
    span   = LAT + ((w == 0) ? 3 : w + 3);
    driveLine(which, 1'b0);
    for (int k = 1; k <= span; k++) begin
      @(negedge clk);
      if (k == w) driveLine(which, 1'b1);
      expLow  = passes && (k >= LAT) && ((w == 0) || (k < LAT + w));
      expFall = passes && (k == LAT);
      checkOutput($sformatf("%s srx_o k=%0d", tag, k), 32'(bus.srx_o), 32'(!expLow));
      checkOutput($sformatf("%s rx_fall k=%0d", tag, k), 32'(bus.rx_fall), 32'(expFall));
    end
  endtask

  int tickCount;

  initial begin
    // Reset with the pad held low, then release.
    wb_rst_ni  = 1'b0;
    applyStimulus(1'b0, 1'b1, 1'b0);
    bus.dl     = '0;
    bus.dl_we  = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset srx_o", 32'(bus.srx_o), 32'd1);
    checkOutput("reset rx_fall", 32'(bus.rx_fall), 32'd0);
    checkOutput("reset enable", 32'(bus.enable), 32'd0);
    wb_rst_ni = 1'b1;
    for (int k = 1; k <= LAT + 2; k++) begin
      @(negedge clk);
      checkOutput($sformatf("release srx_o k=%0d", k), 32'(bus.srx_o), 32'(k < LAT));
      checkOutput($sformatf("release rx_fall k=%0d", k), 32'(bus.rx_fall), 32'(k == LAT));
    end
    applyStimulus(1'b1, 1'b1, 1'b0);
    repeat (LAT + 3) @(negedge clk);
    checkOutput("idle srx_o", 32'(bus.srx_o), 32'd1);

    // Divisor counter.
    loadDivisor(5);
    watchEnable("dl5", 16, 5, 5);
    loadDivisor(1);
    watchEnable("dl1", 5, 1, 1);
    bus.dl    = '0;
    tickCount = 0;
    repeat (100) begin
      @(negedge clk);
      if (bus.enable) tickCount++;
    end
    checkOutput("dl0 tick count", 32'(tickCount), 32'd0);
    loadDivisor(3);
    watchEnable("dl3 first", 3, 3, 3);

    // Rewrite the divisor when the old phase is two cycles from a tick.
    loadDivisor(5);
    for (int k = 1; k <= 2; k++) begin
      @(negedge clk);
      checkOutput($sformatf("old phase k=%0d", k), 32'(bus.enable), 32'd0);
    end
    loadDivisor(8);
    watchEnable("rewrite", 10, 8, 8);
    bus.dl = '0;

    // Glitch handling on the pad path.
    watchPulse("pulse1", 1, 0);
    watchPulse("pulse2", 2, 0);
    watchPulse("pulse3", 3, 0);

    // Loopback path follows stx_pad_i and ignores srx_pad_i.
    applyStimulus(1'b1, 1'b1, 1'b1);
    repeat (4) @(negedge clk);
    watchPulse("loop stx", 4, 1);
    applyStimulus(1'b0, 1'b1, 1'b1);
    repeat (LAT + 3) @(negedge clk);
    checkOutput("loop masks srx", 32'(bus.srx_o), 32'd1);
    watchPulse("loop off", 0, 2);

    // Mid-operation reset clears the tick at once and idles the line.
    loadDivisor(1);
    repeat (2) @(negedge clk);
    checkOutput("pre-reset enable", 32'(bus.enable), 32'd1);
    #2 wb_rst_ni = 1'b0;
    #1;
    checkOutput("mid reset enable", 32'(bus.enable), 32'd0);
    checkOutput("mid reset srx_o", 32'(bus.srx_o), 32'd1);
    checkOutput("mid reset rx_fall", 32'(bus.rx_fall), 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    @(negedge clk);
    wb_rst_ni = 1'b1;
    for (int k = 1; k <= LAT + 2; k++) begin
      @(negedge clk);
      checkOutput($sformatf("post-reset srx_o k=%0d", k), 32'(bus.srx_o), 32'd1);
      checkOutput($sformatf("post-reset rx_fall k=%0d", k), 32'(bus.rx_fall), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
